// File: rtl/alu_arbiter.sv
// alu_arbiter: two-port round-robin arbiter/sequencer in front of the shared
// registered ALU. Accepts one (a, b, f) request at a time, drives the ALU
// operand registers, waits out the ALU's one-cycle latency, then returns
// y/cout to the winning port over a per-port valid/ready response handshake.
//
// Build option: define ALU_ARB_FIXED_PRIO_EN for fixed priority (port 0 always
// wins simultaneous requests, no pointer). Default build is round-robin.
module alu_arbiter #(
    parameter int DATA_W = 5,
    parameter int F_W    = 3
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic [F_W-1:0]    req0_f,

    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic [F_W-1:0]    req1_f,

    output logic              rsp0_valid,
    input  logic              rsp0_ready,
    output logic [DATA_W-1:0] rsp0_y,
    output logic              rsp0_cout,

    output logic              rsp1_valid,
    input  logic              rsp1_ready,
    output logic [DATA_W-1:0] rsp1_y,
    output logic              rsp1_cout,

    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [F_W-1:0]    alu_f,
    input  logic [DATA_W-1:0] alu_y,
    input  logic              alu_cout
);

    // IDLE: accept, ISSUE: ALU samples, CAPTURE: latch ALU result, RESP: hand back
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        RESP    = 2'd3
    } state_e;

    state_e            state_q;
    logic              owner_q;      // port that owns the in-flight operation

    logic [DATA_W-1:0] alu_a_q;
    logic [DATA_W-1:0] alu_b_q;
    logic [F_W-1:0]    alu_f_q;

    logic              rsp0_valid_q;
    logic [DATA_W-1:0] rsp0_y_q;
    logic              rsp0_cout_q;
    logic              rsp1_valid_q;
    logic [DATA_W-1:0] rsp1_y_q;
    logic              rsp1_cout_q;

`ifndef ALU_ARB_FIXED_PRIO_EN
    logic              ptr_q;        // port favoured when both request
`endif

    logic              grant0_d;
    logic              grant1_d;
    logic              owner_rsp_ready;

    // Pick at most one winner, only while idle and out of reset (ready is combinational)
    always_comb begin
        grant0_d = 1'b0;
        grant1_d = 1'b0;
        if (rst_n && (state_q == IDLE)) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
            grant0_d = req0_valid;
            grant1_d = req1_valid & ~req0_valid;
`else
            if (req0_valid && req1_valid) begin
                grant0_d = ~ptr_q;
                grant1_d = ptr_q;
            end else begin
                grant0_d = req0_valid;
                grant1_d = req1_valid;
            end
`endif
        end
    end

    // Response-consume signal of whichever port currently owns the operation
    always_comb begin
        owner_rsp_ready = owner_q ? rsp1_ready : rsp0_ready;
    end

    // Sequencer FSM with all datapath/response registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            owner_q      <= 1'b0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_f_q      <= '0;
            rsp0_valid_q <= 1'b0;
            rsp0_y_q     <= '0;
            rsp0_cout_q  <= 1'b0;
            rsp1_valid_q <= 1'b0;
            rsp1_y_q     <= '0;
            rsp1_cout_q  <= 1'b0;
`ifndef ALU_ARB_FIXED_PRIO_EN
            ptr_q        <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant0_d || grant1_d) begin
                        // Operands stay frozen here until the next grant
                        alu_a_q <= grant1_d ? req1_a : req0_a;
                        alu_b_q <= grant1_d ? req1_b : req0_b;
                        alu_f_q <= grant1_d ? req1_f : req0_f;
                        owner_q <= grant1_d;
`ifndef ALU_ARB_FIXED_PRIO_EN
                        // Favour the other port next time
                        ptr_q   <= grant0_d;
`endif
                        state_q <= ISSUE;
                    end
                end
                ISSUE: begin
                    state_q <= CAPTURE;
                end
                CAPTURE: begin
                    // ALU output now reflects the operands issued last cycle
                    if (owner_q) begin
                        rsp1_y_q     <= alu_y;
                        rsp1_cout_q  <= alu_cout;
                        rsp1_valid_q <= 1'b1;
                    end else begin
                        rsp0_y_q     <= alu_y;
                        rsp0_cout_q  <= alu_cout;
                        rsp0_valid_q <= 1'b1;
                    end
                    state_q <= RESP;
                end
                RESP: begin
                    if (owner_rsp_ready) begin
                        rsp0_valid_q <= 1'b0;
                        rsp1_valid_q <= 1'b0;
                        state_q      <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign req0_ready = grant0_d;
    assign req1_ready = grant1_d;

    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_f      = alu_f_q;

    assign rsp0_valid = rsp0_valid_q;
    assign rsp0_y     = rsp0_y_q;
    assign rsp0_cout  = rsp0_cout_q;
    assign rsp1_valid = rsp1_valid_q;
    assign rsp1_y     = rsp1_y_q;
    assign rsp1_cout  = rsp1_cout_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Testbench for alu_arbiter: behavioural registered-ALU stand-in plus a
// transaction-level reference model (grant rule, pointer, expected result).
module tb_alu_arbiter;

    localparam int DATA_W = 5;
    localparam int F_W    = 3;

`ifdef ALU_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              v[2];
    logic [DATA_W-1:0] a[2];
    logic [DATA_W-1:0] b[2];
    logic [F_W-1:0]    f[2];
    logic              rsp_rdy[2];

    logic              req0_ready, req1_ready;
    logic              rsp0_valid, rsp1_valid;
    logic [DATA_W-1:0] rsp0_y, rsp1_y;
    logic              rsp0_cout, rsp1_cout;
    logic [DATA_W-1:0] alu_a, alu_b;
    logic [F_W-1:0]    alu_f;
    logic [DATA_W:0]   alu_q = '0;

    int checks = 0;
    int errors = 0;
    bit m_ptr  = 1'b0;

    always #5 clk = ~clk;

    alu_arbiter #(.DATA_W(DATA_W), .F_W(F_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (v[0]),
        .req0_ready (req0_ready),
        .req0_a     (a[0]),
        .req0_b     (b[0]),
        .req0_f     (f[0]),
        .req1_valid (v[1]),
        .req1_ready (req1_ready),
        .req1_a     (a[1]),
        .req1_b     (b[1]),
        .req1_f     (f[1]),
        .rsp0_valid (rsp0_valid),
        .rsp0_ready (rsp_rdy[0]),
        .rsp0_y     (rsp0_y),
        .rsp0_cout  (rsp0_cout),
        .rsp1_valid (rsp1_valid),
        .rsp1_ready (rsp_rdy[1]),
        .rsp1_y     (rsp1_y),
        .rsp1_cout  (rsp1_cout),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_f      (alu_f),
        .alu_y      (alu_q[DATA_W-1:0]),
        .alu_cout   (alu_q[DATA_W])
    );

    // 5-bit ALU: f[2] inverts b, f[1:0] = and / or / add / set-less-than
    function automatic logic [DATA_W:0] alu_fn(input logic [DATA_W-1:0] x,
                                               input logic [DATA_W-1:0] y,
                                               input logic [F_W-1:0] fc);
        logic [DATA_W-1:0] bb;
        logic [DATA_W:0]   s;
        logic [DATA_W-1:0] r;
        bb = fc[2] ? ~y : y;
        s  = {1'b0, x} + {1'b0, bb};
        case (fc[1:0])
            2'b00:   r = x & bb;
            2'b01:   r = x | bb;
            2'b10:   r = s[DATA_W-1:0];
            default: r = {{(DATA_W-1){1'b0}}, s[DATA_W-1]};
        endcase
        return {s[DATA_W], r};
    endfunction

    // Registered ALU stand-in: output follows its inputs one edge later
    always @(posedge clk) alu_q <= alu_fn(alu_a, alu_b, alu_f);

    task automatic arm(input bit p);
        v[p] = 1'b1;
        a[p] = DATA_W'($urandom_range(0, 31));
        b[p] = DATA_W'($urandom_range(0, 31));
        f[p] = F_W'($urandom_range(0, 7));
    endtask

    // One complete transaction from an IDLE cycle; caller has set valids/operands.
    task automatic serve_one(input bit refill, input int bp, output bit gport,
                             output logic [DATA_W-1:0] oy, output logic ocout);
        bit                ex;
        logic [DATA_W:0]   exp_r;
        logic [DATA_W-1:0] ea, eb;
        logic [F_W-1:0]    ef;
        oy = '0;
        ocout = 1'b0;
        @(negedge clk);
        if (v[0] && v[1]) ex = FIXED ? 1'b0 : m_ptr;
        else              ex = v[0] ? 1'b0 : 1'b1;
        checks++;
        if (req0_ready !== (ex == 1'b0) || req1_ready !== (ex == 1'b1)) begin
            errors++;
            $display("FAIL grant: ready0=%b ready1=%b, required winner port %0d", req0_ready, req1_ready, ex);
        end
        checks++;
        if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) begin
            errors++;
            $display("FAIL idle_rsp: rsp0_valid=%b rsp1_valid=%b, required 0 0", rsp0_valid, rsp1_valid);
        end
        ea = a[ex]; eb = b[ex]; ef = f[ex];
        exp_r = alu_fn(ea, eb, ef);
        gport = ex;
        @(posedge clk); #1;
        if (!FIXED) m_ptr = ~ex;
        if (refill) arm(ex);
        else v[ex] = 1'b0;
        rsp_rdy[ex]  = (bp == 0);
        rsp_rdy[~ex] = 1'($urandom_range(0, 1));
        // ISSUE cycle
        @(negedge clk);
        checks++;
        if (alu_a !== ea || alu_b !== eb || alu_f !== ef) begin
            errors++;
            $display("FAIL issue_ops: alu a/b/f=%0d/%0d/%0d, required %0d/%0d/%0d", alu_a, alu_b, alu_f, ea, eb, ef);
        end
        checks++;
        if (req0_ready || req1_ready || rsp0_valid || rsp1_valid) begin
            errors++;
            $display("FAIL issue_ctl: ready=%b%b rspv=%b%b, required all 0", req0_ready, req1_ready, rsp0_valid, rsp1_valid);
        end
        @(posedge clk); #1;
        // CAPTURE cycle
        @(negedge clk);
        checks++;
        if (req0_ready || req1_ready || rsp0_valid || rsp1_valid) begin
            errors++;
            $display("FAIL capture_ctl: ready=%b%b rspv=%b%b, required all 0", req0_ready, req1_ready, rsp0_valid, rsp1_valid);
        end
        @(posedge clk); #1;
        // RESP cycles, bp of them with the owner backpressuring
        for (int i = 0; i <= bp; i++) begin
            @(negedge clk);
            oy    = ex ? rsp1_y : rsp0_y;
            ocout = ex ? rsp1_cout : rsp0_cout;
            checks++;
            if ((ex ? rsp1_valid : rsp0_valid) !== 1'b1 || (ex ? rsp0_valid : rsp1_valid) !== 1'b0 ||
                oy !== exp_r[DATA_W-1:0] || ocout !== exp_r[DATA_W]) begin
                errors++;
                $display("FAIL resp port%0d: rspv=%b%b y=%0d cout=%b, required owner valid y=%0d cout=%b",
                         ex, rsp1_valid, rsp0_valid, oy, ocout, exp_r[DATA_W-1:0], exp_r[DATA_W]);
            end
            checks++;
            if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
                errors++;
                $display("FAIL resp_ready: ready0=%b ready1=%b, required 0 0", req0_ready, req1_ready);
            end
            rsp_rdy[ex] = (i == bp);
            @(posedge clk); #1;
        end
        checks++;
        if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) begin
            errors++;
            $display("FAIL resp_clear: rsp0_valid=%b rsp1_valid=%b, required 0 0", rsp0_valid, rsp1_valid);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        v[0] = 1'b1; v[1] = 1'b1;
        a[0] = 5'd3; b[0] = 5'd4; f[0] = 3'd2;
        a[1] = 5'd1; b[1] = 5'd2; f[1] = 3'd1;
        rsp_rdy[0] = 1'b1; rsp_rdy[1] = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (req0_ready || req1_ready || rsp0_valid || rsp1_valid || alu_a !== 5'd0 || alu_b !== 5'd0 ||
            alu_f !== 3'd0 || rsp0_y !== 5'd0 || rsp1_y !== 5'd0 || rsp0_cout || rsp1_cout) begin
            errors++;
            $display("FAIL reset_state: ready=%b%b rspv=%b%b alu=%0d/%0d/%0d y=%0d/%0d, required all 0",
                     req0_ready, req1_ready, rsp0_valid, rsp1_valid, alu_a, alu_b, alu_f, rsp0_y, rsp1_y);
        end
        v[0] = 1'b0; v[1] = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        m_ptr = 1'b0;
    endtask

    task automatic test_single_add();
        bit g; logic [DATA_W-1:0] y; logic c;
        v[0] = 1'b1; a[0] = 5'd5; b[0] = 5'd7; f[0] = 3'b010; v[1] = 1'b0;
        rsp_rdy[0] = 1'b1;
        serve_one(1'b0, 0, g, y, c);
        checks++;
        if (g !== 1'b0 || y !== 5'd12 || c !== 1'b0) begin
            errors++;
            $display("FAIL single_add: port=%0d y=%0d cout=%b, required port 0 y=12 cout=0", g, y, c);
        end
    endtask

    task automatic test_inv_add();
        bit g; logic [DATA_W-1:0] y; logic c;
        v[1] = 1'b1; a[1] = 5'd10; b[1] = 5'd3; f[1] = 3'b110; v[0] = 1'b0;
        serve_one(1'b0, 0, g, y, c);
        checks++;
        if (g !== 1'b1 || y !== 5'd6 || c !== 1'b1) begin
            errors++;
            $display("FAIL inv_add: port=%0d y=%0d cout=%b, required port 1 y=6 cout=1", g, y, c);
        end
    endtask

    task automatic test_back_to_back();
        bit g; logic [DATA_W-1:0] y; logic c;
        arm(1'b0); v[1] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            serve_one(i < 2, 0, g, y, c);
            checks++;
            if (g !== 1'b0) begin
                errors++;
                $display("FAIL back_to_back op%0d: port=%0d, required 0", i, g);
            end
        end
    endtask

    task automatic test_backpressure();
        bit g; logic [DATA_W-1:0] y; logic c;
        v[0] = 1'b0; arm(1'b1);
        serve_one(1'b0, 0, g, y, c);
        arm(1'b0); arm(1'b1);
        serve_one(1'b0, 5, g, y, c);
        checks++;
        if (g !== 1'b0) begin
            errors++;
            $display("FAIL backpressure_grant: port=%0d, required 0", g);
        end
        serve_one(1'b0, 0, g, y, c);
        checks++;
        if (g !== 1'b1) begin
            errors++;
            $display("FAIL backpressure_next: port=%0d, required 1", g);
        end
    endtask

    task automatic test_reset_mid();
        bit g; logic [DATA_W-1:0] y; logic c;
        v[0] = 1'b1; a[0] = 5'd9; b[0] = 5'd9; f[0] = 3'b010; v[1] = 1'b0;
        rsp_rdy[0] = 1'b0; rsp_rdy[1] = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        v[1] = 1'b1; a[1] = 5'd4; b[1] = 5'd1; f[1] = 3'b001;
        checks++;
        if (rsp0_valid !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_resp: rsp0_valid=%b, required 1", rsp0_valid);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (rsp0_valid || rsp1_valid || req0_ready || req1_ready || alu_a !== 5'd0 || alu_b !== 5'd0 || alu_f !== 3'd0) begin
            errors++;
            $display("FAIL reset_mid: rspv=%b%b ready=%b%b alu=%0d/%0d/%0d, required all 0",
                     rsp0_valid, rsp1_valid, req0_ready, req1_ready, alu_a, alu_b, alu_f);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        m_ptr = 1'b0;
        rsp_rdy[0] = 1'b1; rsp_rdy[1] = 1'b1;
        serve_one(1'b0, 0, g, y, c);
        checks++;
        if (g !== 1'b0) begin
            errors++;
            $display("FAIL reset_first_grant: port=%0d, required 0", g);
        end
        serve_one(1'b0, 0, g, y, c);
    endtask

    task automatic test_simultaneous_streams();
        bit g, prev, eg, seen0;
        logic [DATA_W-1:0] y; logic c;
        seen0 = 1'b0;
        prev = 1'b0;
        arm(1'b1);
        v[0] = 1'b1; a[0] = 5'd2; b[0] = 5'd9; f[0] = 3'b111;
        rsp_rdy[0] = 1'b1; rsp_rdy[1] = 1'b1;
        for (int i = 0; i < 8; i++) begin
            eg = FIXED ? 1'b0 : ((i == 0) ? m_ptr : ~prev);
            serve_one(1'b1, 0, g, y, c);
            checks++;
            if (g !== eg) begin
                errors++;
                $display("FAIL stream_order op%0d: port=%0d, required %0d", i, g, eg);
            end
            if (g == 1'b0 && !seen0) begin
                seen0 = 1'b1;
                checks++;
                if (y !== 5'd1 || c !== 1'b0) begin
                    errors++;
                    $display("FAIL stream_slt: y=%0d cout=%b, required y=1 cout=0", y, c);
                end
            end
            prev = g;
        end
    endtask

    task automatic test_random();
        bit g; logic [DATA_W-1:0] y; logic c;
        for (int i = 0; i < 40; i++) begin
            if (!v[0] && $urandom_range(0, 1) == 1) arm(1'b0);
            if (!v[1] && $urandom_range(0, 1) == 1) arm(1'b1);
            if (!v[0] && !v[1]) arm(1'($urandom_range(0, 1)));
            serve_one(1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), g, y, c);
        end
    endtask

    initial begin
        v[0] = 1'b0; v[1] = 1'b0;
        a[0] = '0; a[1] = '0; b[0] = '0; b[1] = '0; f[0] = '0; f[1] = '0;
        rsp_rdy[0] = 1'b0; rsp_rdy[1] = 1'b0;
        test_reset();
        test_single_add();
        test_inv_add();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        test_simultaneous_streams();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
